// File: rtl/huffman_gen.sv
// Framed symbol histogram followed by an iterative Huffman code builder.
// Each merge costs NSYM scan cycles plus one merge cycle; ties always resolve to the lowest slot.
module huffman_sym #(
    parameter int IW   = 3,
    parameter int LW   = 8,
    parameter int LENW = 4,
    parameter int SELF = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            init,
    input  logic            merge,
    input  logic [IW-1:0]   min1,
    input  logic [IW-1:0]   min2,
    output logic [LW-1:0]   code,
    output logic [LW-1:0]   code_nxt,
    output logic [LENW-1:0] len,
    output logic [LENW-1:0] len_nxt
);
    logic [IW-1:0] grp, grp_nxt;

    // grp is the slot whose tree currently contains this symbol
    always_comb begin
        code_nxt = code;
        len_nxt  = len;
        grp_nxt  = grp;
        if (merge) begin
            if (grp == min1) begin
                code_nxt = code | (LW'(1) << len);
                len_nxt  = len + 1'b1;
                grp_nxt  = min2;
            end else if (grp == min2) begin
                len_nxt  = len + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            code <= '0;
            len  <= '0;
            grp  <= '0;
        end else if (init) begin
            code <= '0;
            len  <= '0;
            grp  <= IW'(SELF);
        end else begin
            code <= code_nxt;
            len  <= len_nxt;
            grp  <= grp_nxt;
        end
    end
endmodule

module huffman_gen #(
    parameter int NSYM = 6,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int LW   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gray_valid,
    input  logic [DW-1:0]      gray_data,
    input  logic               gray_last,
    output logic               in_ready,
    output logic               CNT_valid,
    output logic [NSYM*CW-1:0] CNT_bus,
    output logic               code_valid,
    output logic [NSYM*LW-1:0] HC_bus,
    output logic [NSYM*LW-1:0] M_bus,
    output logic               sym_err,
    output logic               cnt_sat
);
    localparam int IW   = $clog2(NSYM);
    localparam int AW   = $clog2(NSYM + 1);
    localparam int LENW = $clog2(LW + 1);
    localparam int WW   = CW + 1;

    typedef enum logic [2:0] {ACCEPT, PUBLISH, SCAN, MERGE, DONE} state_t;
    state_t state;

    logic [NSYM-1:0][CW-1:0]   cnt, cnt_nxt, cnt_out;
    logic [NSYM-1:0][LW-1:0]   hc_out, m_out, code_q, code_nxt;
    logic [NSYM-1:0][LENW-1:0] len_q, len_nxt;
    logic [NSYM-1:0][WW-1:0]   w;
    logic [NSYM-1:0]           active;
    logic                      err_q, sat_q, err_nxt, sat_nxt, degen;
    logic [AW-1:0]             act_cnt, nz;
    logic [IW-1:0]             scan_idx, min1, min2, sym_idx;
    logic                      m1v, m2v, sym_ok, latch_en;
    logic [WW-1:0]             m1w, m2w;
    logic [WW:0]               sum;

    assign CNT_bus = cnt_out;
    assign HC_bus  = hc_out;
    assign M_bus   = m_out;

    assign sym_ok  = (gray_data != '0) && (32'(gray_data) <= NSYM);
    assign sym_idx = IW'(gray_data - 1'b1);
    assign sum     = {1'b0, m1w} + {1'b0, m2w};
    // Codes are published from the merged values so code_valid lands in the DONE cycle
    assign latch_en = (state == MERGE && act_cnt == AW'(2)) || (state == DONE && degen);

    always_comb begin
        cnt_nxt = cnt;
        err_nxt = err_q;
        sat_nxt = sat_q;
        if (state == ACCEPT && gray_valid) begin
            if (!sym_ok)
                err_nxt = 1'b1;
            else if (cnt[sym_idx] == '1)
                sat_nxt = 1'b1;
            else
                cnt_nxt[sym_idx] = cnt[sym_idx] + 1'b1;
        end
    end

    always_comb begin
        nz = '0;
        for (int i = 0; i < NSYM; i++)
            nz = nz + AW'(cnt[i] != '0);
    end

    for (genvar g = 0; g < NSYM; g++) begin : g_sym
        huffman_sym #(.IW(IW), .LW(LW), .LENW(LENW), .SELF(g)) u_sym (
            .clk      (clk),
            .reset    (reset),
            .clear    (state == DONE),
            .init     (state == PUBLISH),
            .merge    (state == MERGE),
            .min1     (min1),
            .min2     (min2),
            .code     (code_q[g]),
            .code_nxt (code_nxt[g]),
            .len      (len_q[g]),
            .len_nxt  (len_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCEPT;
            in_ready   <= 1'b1;
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            cnt_out    <= '0;
            hc_out     <= '0;
            m_out      <= '0;
            sym_err    <= 1'b0;
            cnt_sat    <= 1'b0;
            cnt        <= '0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
            active     <= '0;
            w          <= '0;
            act_cnt    <= '0;
            scan_idx   <= '0;
            min1       <= '0;
            min2       <= '0;
            m1v        <= 1'b0;
            m2v        <= 1'b0;
            m1w        <= '0;
            m2w        <= '0;
            degen      <= 1'b0;
        end else begin
            CNT_valid  <= 1'b0;
            code_valid <= latch_en;
            case (state)
                ACCEPT: begin
                    cnt   <= cnt_nxt;
                    err_q <= err_nxt;
                    sat_q <= sat_nxt;
                    if (gray_valid && gray_last) begin
                        cnt_out   <= cnt_nxt;
                        sym_err   <= err_nxt;
                        cnt_sat   <= sat_nxt;
                        CNT_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    for (int i = 0; i < NSYM; i++) begin
                        active[i] <= (cnt[i] != '0);
                        w[i]      <= {1'b0, cnt[i]};
                    end
                    act_cnt  <= nz;
                    scan_idx <= '0;
                    m1v      <= 1'b0;
                    m2v      <= 1'b0;
                    if (nz <= AW'(1)) begin
                        degen <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // strict compares keep the earlier (lower) slot on ties
                    if (active[scan_idx]) begin
                        if (!m1v || w[scan_idx] < m1w) begin
                            min2 <= min1;
                            m2w  <= m1w;
                            m2v  <= m1v;
                            min1 <= scan_idx;
                            m1w  <= w[scan_idx];
                            m1v  <= 1'b1;
                        end else if (!m2v || w[scan_idx] < m2w) begin
                            min2 <= scan_idx;
                            m2w  <= w[scan_idx];
                            m2v  <= 1'b1;
                        end
                    end
                    if (scan_idx == IW'(NSYM - 1))
                        state <= MERGE;
                    else
                        scan_idx <= scan_idx + 1'b1;
                end
                MERGE: begin
                    w[min2]      <= sum[WW] ? '1 : sum[WW-1:0];
                    active[min1] <= 1'b0;
                    act_cnt      <= act_cnt - 1'b1;
                    scan_idx     <= '0;
                    m1v          <= 1'b0;
                    m2v          <= 1'b0;
                    state        <= (act_cnt == AW'(2)) ? DONE : SCAN;
                end
                DONE: begin
                    cnt      <= '0;
                    err_q    <= 1'b0;
                    sat_q    <= 1'b0;
                    active   <= '0;
                    w        <= '0;
                    act_cnt  <= '0;
                    degen    <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= ACCEPT;
                end
                default: state <= ACCEPT;
            endcase
            if (latch_en) begin
                for (int i = 0; i < NSYM; i++) begin
                    hc_out[i] <= code_nxt[i];
                    m_out[i]  <= degen ? {{(LW-1){1'b0}}, active[i]}
                                       : (LW'(1) << len_nxt[i]) - LW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_gen.sv
// Scoreboard bench for huffman_gen: stimulus pushes expected histograms/codes, monitors pop on valid pulses.
module tb_huffman_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gray_valid = 1'b0, gv4 = 1'b0;
    logic [7:0]  gray_data = '0;
    logic        gray_last = 1'b0;

    logic        in_ready, CNT_valid, code_valid, sym_err, cnt_sat;
    logic [47:0] CNT_bus, HC_bus, M_bus;
    logic        in_ready4, CNT_valid4, code_valid4, sym_err4, cnt_sat4;
    logic [23:0] CNT_bus4;
    logic [47:0] HC_bus4, M_bus4;

    always #5 clk = ~clk;

    huffman_gen dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .gray_last(gray_last), .in_ready(in_ready), .CNT_valid(CNT_valid), .CNT_bus(CNT_bus),
        .code_valid(code_valid), .HC_bus(HC_bus), .M_bus(M_bus), .sym_err(sym_err), .cnt_sat(cnt_sat)
    );

    huffman_gen #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .gray_valid(gv4), .gray_data(gray_data),
        .gray_last(gray_last), .in_ready(in_ready4), .CNT_valid(CNT_valid4), .CNT_bus(CNT_bus4),
        .code_valid(code_valid4), .HC_bus(HC_bus4), .M_bus(M_bus4), .sym_err(sym_err4), .cnt_sat(cnt_sat4)
    );

    typedef struct { logic [47:0] cnt; logic err; logic sat; } cnt_exp_t;
    typedef struct { logic [47:0] hc; logic [47:0] m; int lat; } code_exp_t;

    cnt_exp_t  cq[$], cq4[$];
    code_exp_t kq[$], kq4[$];
    int total = 0, bad = 0;
    int cyc = 0, cnt_cyc = 0, cnt_cyc4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] p6(input logic [7:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic push(input logic [47:0] c, input logic err, input logic sat,
                        input logic [47:0] hc, input logic [47:0] m, input int lat);
        cq.push_back('{c, err, sat});
        kq.push_back('{hc, m, lat});
    endtask

    always @(negedge clk) begin
        cnt_exp_t  ce;
        code_exp_t ke;
        if (CNT_valid) begin
            cnt_cyc = cyc;
            if (cq.size() == 0) chk("cnt_unexpected", 48'd1, 48'd0);
            else begin
                ce = cq.pop_front();
                chk("cnt_bus", CNT_bus, ce.cnt);
                chk("sym_err", 48'(sym_err), 48'(ce.err));
                chk("cnt_sat", 48'(cnt_sat), 48'(ce.sat));
            end
        end
        if (code_valid) begin
            if (kq.size() == 0) chk("code_unexpected", 48'd1, 48'd0);
            else begin
                ke = kq.pop_front();
                chk("hc_bus", HC_bus, ke.hc);
                chk("m_bus", M_bus, ke.m);
                chk("code_latency", 48'(cyc - cnt_cyc), 48'(ke.lat));
            end
        end
        if (CNT_valid4) begin
            cnt_cyc4 = cyc;
            if (cq4.size() == 0) chk("cnt4_unexpected", 48'd1, 48'd0);
            else begin
                ce = cq4.pop_front();
                chk("cnt4_bus", 48'(CNT_bus4), ce.cnt);
                chk("sym_err4", 48'(sym_err4), 48'(ce.err));
                chk("cnt_sat4", 48'(cnt_sat4), 48'(ce.sat));
            end
        end
        if (code_valid4) begin
            if (kq4.size() == 0) chk("code4_unexpected", 48'd1, 48'd0);
            else begin
                ke = kq4.pop_front();
                chk("hc4_bus", HC_bus4, ke.hc);
                chk("m4_bus", M_bus4, ke.m);
                chk("code4_latency", 48'(cyc - cnt_cyc4), 48'(ke.lat));
            end
        end
    end

    task automatic send(input int d, input bit last);
        int t = 0;
        while (!in_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) chk("in_ready_timeout", 48'd0, 48'd1);
        gray_valid = 1'b1;
        gray_data  = 8'(d);
        gray_last  = last;
        @(posedge clk); #1;
        gray_valid = 1'b0;
        gray_last  = 1'b0;
    endtask

    // bad samples (alternating 0 and 7) go first, then c[k] samples of symbol k+1
    task automatic frame(input int c[6], input int nbad);
        int tot = 0, sent = 0;
        for (int k = 0; k < 6; k++) tot += c[k];
        for (int b = 0; b < nbad; b++)
            send((b % 2 == 0) ? 0 : 7, (b == nbad - 1) && (tot == 0));
        for (int k = 0; k < 6; k++)
            for (int n = 0; n < c[k]; n++) begin
                sent++;
                send(k + 1, sent == tot);
            end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 48'(in_ready), 48'd1);
        chk({tag, "_cnt_bus"}, CNT_bus, 48'd0);
        chk({tag, "_hc_bus"}, HC_bus, 48'd0);
        chk({tag, "_m_bus"}, M_bus, 48'd0);
        chk({tag, "_valids"}, {46'd0, CNT_valid, code_valid}, 48'd0);
        chk({tag, "_flags"}, {46'd0, sym_err, cnt_sat}, 48'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset");

        push(p6(40, 30, 15, 10, 4, 1), 1'b1, 1'b0,
             p6(8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h03),
             p6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 36);
        frame('{40, 30, 15, 10, 4, 1}, 2);

        push(p6(0, 3, 0, 0, 7, 0), 1'b0, 1'b0,
             p6(0, 1, 0, 0, 0, 0), p6(0, 1, 0, 0, 1, 0), 8);
        frame('{0, 3, 0, 0, 7, 0}, 0);
        // strobes while the tree is being built must be refused
        repeat (2) @(posedge clk);
        #1;
        gray_valid = 1'b1; gray_data = 8'd0; gray_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("in_ready_scan", 48'(in_ready), 48'd0);
            @(posedge clk); #1;
        end
        gray_valid = 1'b0; gray_last = 1'b0;

        push(p6(0, 0, 0, 9, 0, 0), 1'b0, 1'b0, 48'd0, p6(0, 0, 0, 1, 0, 0), 2);
        frame('{0, 0, 0, 9, 0, 0}, 0);

        push(48'd0, 1'b1, 1'b0, 48'd0, 48'd0, 2);
        frame('{0, 0, 0, 0, 0, 0}, 1);

        // A=2: SCAN occupies 6 cycles after PUBLISH, MERGE is the 7th
        cq.push_back('{p6(2, 1, 0, 0, 0, 0), 1'b0, 1'b0});
        frame('{2, 1, 0, 0, 0, 0}, 0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_idle("mid_reset");

        push(p6(40, 30, 15, 10, 4, 1), 1'b0, 1'b0,
             p6(8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h03),
             p6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 36);
        frame('{40, 30, 15, 10, 4, 1}, 0);

        // 4-bit counters: 20 samples of symbol 1 saturate at 15
        cq4.push_back('{48'h0F, 1'b0, 1'b1});
        kq4.push_back('{48'd0, 48'h01, 2});
        for (int i = 0; i < 20; i++) begin
            gv4 = 1'b1; gray_data = 8'd1; gray_last = (i == 19);
            @(posedge clk); #1;
        end
        gv4 = 1'b0; gray_last = 1'b0;

        t = 0;
        while ((cq.size() + kq.size() + cq4.size() + kq4.size()) != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 48'(cq.size() + kq.size() + cq4.size() + kq4.size()), 48'd0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
